// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and frame layout for the SPI responder
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        W_HOLD  = 3'd2,
        R_WAIT  = 3'd3,
        R_SHIFT = 3'd4
    } state_t;

    localparam int SPI_ADDR_WIDTH = 3;
    localparam int SPI_DATA_WIDTH = 8;
    localparam int CMD_WIDTH      = 1 + SPI_ADDR_WIDTH + SPI_DATA_WIDTH;
    localparam int RW_BIT         = 11;
    localparam int ADDR_HI        = 10;
    localparam int ADDR_LO        = 8;
    localparam int DATA_HI        = 7;
    localparam int DATA_LO        = 0;
    localparam int RD_CMD_BITS    = 1 + SPI_ADDR_WIDTH;

endpackage

// File: rtl/spi_if.sv
// rtl/spi_if.sv - four-wire SPI bus bundle with master and slave views
interface spi_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs, output mosi, input miso);
    modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - 2-flop synchronizer with rise/fall pulses for one async input
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder with 8x8 register bank; SPI_SLAVE_FRAME_ERR_EN adds frame_err
module spi_slave
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    spi_if.slave                                  spi,
    output logic                                  wr_vld,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [DATA_WIDTH-1:0]                 wr_data,
    output logic                                  rd_done,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic                                  frame_err,
`endif
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] reg_q
);

    localparam int CNT_W = $clog2(CMD_WIDTH + 1);
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam int RDC_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(CMD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0] RD_CMD_CNT = CNT_W'(RD_CMD_BITS);
    localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(RD_TIMEOUT);
    localparam logic [RDC_W-1:0] RD_FULL    = RDC_W'(DATA_WIDTH);
    localparam logic [RDC_W-1:0] RD_LAST    = RDC_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_s1, mosi_s2;

    spi_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi.sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi.cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk path so mosi_s2 is stable when sclk_rise fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= spi.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    state_t                                 state;
    logic [CNT_W-1:0]                       bit_cnt;
    logic [CMD_WIDTH-1:0]                   shreg_in;
    logic [DATA_WIDTH-1:0]                  shreg_out;
    logic [TMO_W-1:0]                       tmo_cnt;
    logic [RDC_W-1:0]                       rd_cnt;
    logic                                   miso_q;
    logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  bank;

    logic [CMD_WIDTH-1:0]  frame_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  read_ok;
    logic                  err_evt;

    always_comb begin
        frame_next = {shreg_in[CMD_WIDTH-2:0], mosi_s2};
        rd_addr    = shreg_in[ADDR_WIDTH-1:0];
        read_ok    = (bit_cnt == RD_CMD_CNT) && !shreg_in[ADDR_WIDTH];
        err_evt    = 1'b0;
        case (state)
            CMD:     err_evt = cs_rise && !read_ok;
            R_WAIT:  err_evt = !cs_fall && (tmo_cnt == TMO_MAX);
            R_SHIFT: err_evt = cs_rise && (rd_cnt != RD_FULL);
            default: err_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg_in  <= '0;
            shreg_out <= '0;
            tmo_cnt   <= '0;
            rd_cnt    <= '0;
            miso_q    <= 1'b0;
            bank      <= '0;
            wr_vld    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_done   <= 1'b0;
        end else begin
            wr_vld  <= 1'b0;
            rd_done <= 1'b0;
            if (err_evt) begin
                state  <= IDLE;
                miso_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            state    <= CMD;
                            bit_cnt  <= '0;
                            shreg_in <= '0;
                        end
                    end
                    CMD: begin
                        // cs_rise reaching here is always a valid read command
                        if (cs_rise) begin
                            state     <= R_WAIT;
                            shreg_out <= bank[rd_addr*DATA_WIDTH +: DATA_WIDTH];
                            tmo_cnt   <= '0;
                        end else if (sclk_rise && bit_cnt != FULL_CNT) begin
                            shreg_in <= frame_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == LAST_CNT && frame_next[RW_BIT]) begin
                                state   <= W_HOLD;
                                wr_vld  <= 1'b1;
                                wr_addr <= frame_next[ADDR_HI:ADDR_LO];
                                wr_data <= frame_next[DATA_HI:DATA_LO];
                                bank[frame_next[ADDR_HI:ADDR_LO]*DATA_WIDTH +: DATA_WIDTH]
                                        <= frame_next[DATA_HI:DATA_LO];
                            end
                        end
                    end
                    W_HOLD: begin
                        if (cs_rise) state <= IDLE;
                    end
                    R_WAIT: begin
                        if (cs_fall) begin
                            state  <= R_SHIFT;
                            miso_q <= shreg_out[DATA_WIDTH-1];
                            rd_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    R_SHIFT: begin
                        if (cs_rise) begin
                            state  <= IDLE;
                            miso_q <= 1'b0;
                        end else if (sclk_fall) begin
                            shreg_out <= shreg_out << 1;
                            miso_q    <= shreg_out[DATA_WIDTH-2];
                        end else if (sclk_rise && rd_cnt != RD_FULL) begin
                            rd_cnt <= rd_cnt + RDC_W'(1);
                            if (rd_cnt == RD_LAST) rd_done <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        miso_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= err_evt;
    end
`endif

    assign spi.miso = miso_q;
    assign reg_q    = bank;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave
module tb_spi_slave;

    logic        clk;
    logic        rst_n;
    logic        wr_vld;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_done;
    logic [63:0] reg_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
`endif

    spi_if spi();

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi),
        .wr_vld   (wr_vld),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_done  (rd_done),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .reg_q    (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int ferr_exp  = 0;

    logic [10:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  model[8];
    logic [7:0]  rx_byte;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    // Monitor: pops expectations whenever the DUT pulses an output
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_vld) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr_vld", 64'(wr_addr), 64'hDEAD);
                end else begin
                    logic [10:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e[10:8]));
                    check("wr_data", 64'(wr_data), 64'(e[7:0]));
                    check("reg_q_entry", 64'(reg_q[e[10:8]*8 +: 8]), 64'(e[7:0]));
                end
            end
            if (rd_done) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_rd_done", 64'(rx_byte), 64'hDEAD);
                end else begin
                    logic [7:0] b;
                    b = exp_rd.pop_front();
                    check("miso_byte", 64'(rx_byte), 64'(b));
                end
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (frame_err) ferr_seen++;
`endif
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic b);
        spi.mosi = b;
        wait_clk(4);
        rx_byte  = {rx_byte[6:0], spi.miso};
        spi.sclk = 1'b1;
        wait_clk(4);
        spi.sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        spi.cs = 1'b0;
        wait_clk(4);
        for (int i = n - 1; i >= 0; i--) pulse(v[i]);
        wait_clk(4);
        spi.cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        model[a] = d;
        send_bits({4'b0, 1'b1, a, d}, 12);
    endtask

    task automatic read_cmd(input logic [2:0] a, input int hold);
        send_bits({12'b0, 1'b0, a}, 4);
        wait_clk(hold);
    endtask

    task automatic read_shift(input int n);
        rx_byte = 8'h00;
        spi.cs  = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) pulse(1'b0);
        wait_clk(4);
        spi.cs = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        rst_n    = 1'b0;
        spi.cs   = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        rx_byte  = 8'h00;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);

        check("reset_reg_q", reg_q, 64'h0);
        check("reset_miso", 64'(spi.miso), 64'h0);
        check("reset_wr_vld", 64'(wr_vld), 64'h0);
        check("reset_rd_done", 64'(rd_done), 64'h0);

        // 0xA5C: write, addr 2, data 0x5C
        write_reg(3'd2, 8'h5C);
        check("reg2_slice", 64'(reg_q[23:16]), 64'h5C);

        // 0xD3C then read addr 5 after a 100-cycle gap
        write_reg(3'd5, 8'h3C);
        read_cmd(3'd5, 100);
        exp_rd.push_back(8'h3C);
        read_shift(8);
        check("miso_idle_after_read", 64'(spi.miso), 64'h0);

        // Aborted write after 7 bits of 0xFAA
        send_bits(16'h007D, 7);
        ferr_exp++;
        check("bank_after_abort", reg_q, model_flat());

        // Read command with no read phase: times out, then 0x8FF commits
        read_cmd(3'd2, 300);
        ferr_exp++;
        write_reg(3'd0, 8'hFF);
        check("bank_after_timeout", reg_q, model_flat());

        // 0xB77 followed by two extra bits: exactly one commit
        exp_wr.push_back({3'd3, 8'h77});
        model[3] = 8'h77;
        send_bits({2'b0, 12'hB77, 2'b10}, 14);
        check("bank_after_long", reg_q, model_flat());

        // Second read pattern, then a read cut short after 4 bits
        read_cmd(3'd2, 20);
        exp_rd.push_back(8'h5C);
        read_shift(8);
        read_cmd(3'd2, 20);
        read_shift(4);
        ferr_exp++;

        // Reset during R_SHIFT: 0x77 puts bit5 = 1 on miso after two bits
        read_cmd(3'd3, 20);
        rx_byte = 8'h00;
        spi.cs  = 1'b0;
        wait_clk(4);
        pulse(1'b0);
        pulse(1'b0);
        wait_clk(4);
        check("miso_mid_shift", 64'(spi.miso), 64'h1);
        rst_n = 1'b0;
        #1;
        check("miso_in_reset", 64'(spi.miso), 64'h0);
        check("reg_q_in_reset", reg_q, 64'h0);
        spi.cs = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        check("reg_q_after_reset", reg_q, model_flat());

        check("wr_queue_drained", 64'(exp_wr.size()), 64'h0);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err_count", 64'(ferr_seen), 64'(ferr_exp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
